// File: rtl/mem_responder_if.sv
// Bus between the initiator and the memory responder.
// Requests travel master -> slave; ready_o, err_o and rdata_o travel back.
// Request fields stay valid while valid_i is high.
interface mem_responder_if #(
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = 6
);
  logic [WIDTH-1:0]      w_data_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  valid_i;
  logic                  wr_rd_en_i;
  logic [WIDTH-1:0]      rdata_o;
  logic                  ready_o;
  logic                  err_o;

  // Initiator side
  modport master (
    output w_data_i, addr_i, valid_i, wr_rd_en_i,
    input  rdata_o, ready_o, err_o
  );

  // Memory side
  modport slave (
    input  w_data_i, addr_i, valid_i, wr_rd_en_i,
    output rdata_o, ready_o, err_o
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory responder: latches a request, waits WAIT_STATES cycles, then commits it.
// Latency: ready_o pulses WAIT_STATES+1 edges after the accepting edge; one request per WAIT_STATES+2 cycles.
// Backpressure: valid_i is held by the initiator until ready_o; inputs are ignored outside IDLE.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WIDTH       = 4,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int WAIT_STATES = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic                  mem_we;
  logic                  oob;

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  assign oob = int'(addr_q) >= DEPTH;

  // Next-state, request latching and access decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          addr_d  = bus.addr_i;
          wdata_d = bus.w_data_i;
          wr_d    = bus.wr_rd_en_i;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        ready_d = 1'b1;
        err_d   = oob;
        if (wr_q) begin
          mem_we = !oob;
        end else begin
          rdata_d = oob ? '0 : mem_q[addr_q];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset drops any in-flight request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array; cleared on reset, written at the responding edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.ready_o = ready_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: DUT A (DEPTH=64, WAIT_STATES=1) and DUT B (DEPTH=48, WAIT_STATES=0).
// Expected responses are queued when a request is driven and compared when ready_o appears.
// Inputs change #1 after posedge; outputs are sampled at that same point.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.WIDTH(4), .ADDR_WIDTH(6)) bus_a ();
  mem_responder_if #(.WIDTH(4), .ADDR_WIDTH(6)) bus_b ();

  mem_responder #(.DEPTH(64), .WIDTH(4), .ADDR_WIDTH(6), .WAIT_STATES(1)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  mem_responder #(.DEPTH(48), .WIDTH(4), .ADDR_WIDTH(6), .WAIT_STATES(0)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  typedef struct {
    logic [3:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mdl_a [64];
  logic [3:0] mdl_b [64];
  logic [3:0] last_a, last_b;
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic wr,
                       input logic [5:0] a, input logic [3:0] d);
    if (!sel) begin
      bus_a.valid_i = v; bus_a.wr_rd_en_i = wr; bus_a.addr_i = a; bus_a.w_data_i = d;
    end else begin
      bus_b.valid_i = v; bus_b.wr_rd_en_i = wr; bus_b.addr_i = a; bus_b.w_data_i = d;
    end
  endtask

  function automatic logic get_rdy(input bit sel);
    return sel ? bus_b.ready_o : bus_a.ready_o;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? bus_b.err_o : bus_a.err_o;
  endfunction

  function automatic logic [3:0] get_rdata(input bit sel);
    return sel ? bus_b.rdata_o : bus_a.rdata_o;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 64; i++) begin
      mdl_a[i] = 4'h0;
      mdl_b[i] = 4'h0;
    end
    last_a = 4'h0;
    last_b = 4'h0;
  endtask

  // Reference behaviour: A is 64 deep with 1 wait state, B is 48 deep with none.
  task automatic push_exp(input bit sel, input logic wr, input logic [5:0] a, input logic [3:0] d);
    exp_t e;
    e.err = sel ? (int'(a) >= 48) : 1'b0;
    e.lat = sel ? 2 : 3;
    if (!sel) begin
      if (wr) mdl_a[a] = d;
      else    last_a = mdl_a[a];
      e.rdata = last_a;
    end else begin
      if (wr) begin
        if (!e.err) mdl_b[a] = d;
      end else begin
        last_b = e.err ? 4'h0 : mdl_b[a];
      end
      e.rdata = last_b;
    end
    sb.push_back(e);
  endtask

  // One request. chg: swap addr/data after the accepting edge. hold: keep valid high afterwards.
  task automatic do_req(input bit sel, input logic wr, input logic [5:0] a, input logic [3:0] d,
                        input string tag, input bit chg, input logic [5:0] a2,
                        input logic [3:0] d2, input bit hold);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc  = 0;
    seen = 0;
    drive(sel, 1'b1, wr, a, d);
    push_exp(sel, wr, a, d);
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (get_rdy(sel)) seen = 1;
      else if (chg && cyc == 1) drive(sel, 1'b1, wr, a2, d2);
    end
    e = sb.pop_front();
    if (!seen) begin
      check({tag, "_timeout"}, 32'(0), 32'(1));
    end else begin
      check({tag, "_lat"},   32'(cyc),             32'(e.lat));
      check({tag, "_rdata"}, 32'(get_rdata(sel)),  32'(e.rdata));
      check({tag, "_err"},   32'(get_err(sel)),    32'(e.err));
    end
    if (!hold) begin
      drive(sel, 1'b0, 1'b0, 6'd0, 4'h0);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 32'(get_rdy(sel)), 32'(0));
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 6'd0, 4'h0);
    drive(1, 1'b0, 1'b0, 6'd0, 4'h0);
    reset_model();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy_a",   32'(bus_a.ready_o), 32'(0));
    check("rst_rdata_a", 32'(bus_a.rdata_o), 32'(0));
    check("rst_err_a",   32'(bus_a.err_o),   32'(0));
    check("rst_rdy_b",   32'(bus_b.ready_o), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rdy_a", 32'(bus_a.ready_o), 32'(0));
    do_req(0, 1'b0, 6'd5, 4'h0, "rd5_after_rst", 0, 6'd0, 4'h0, 0);

    // Basic write/read and write not disturbing rdata
    do_req(0, 1'b1, 6'd3, 4'hA, "wr3", 0, 6'd0, 4'h0, 0);
    do_req(0, 1'b0, 6'd3, 4'h0, "rd3", 0, 6'd0, 4'h0, 0);
    do_req(0, 1'b1, 6'd9, 4'h2, "wr9_keep", 0, 6'd0, 4'h0, 0);

    // Boundary addresses and aliasing
    do_req(0, 1'b1, 6'd0,  4'h1, "wr0",  0, 6'd0, 4'h0, 0);
    do_req(0, 1'b1, 6'd63, 4'hF, "wr63", 0, 6'd0, 4'h0, 0);
    do_req(0, 1'b1, 6'd32, 4'h7, "wr32", 0, 6'd0, 4'h0, 0);
    do_req(0, 1'b0, 6'd0,  4'h0, "rd0",  0, 6'd0, 4'h0, 0);
    do_req(0, 1'b0, 6'd63, 4'h0, "rd63", 0, 6'd0, 4'h0, 0);
    do_req(0, 1'b0, 6'd32, 4'h0, "rd32", 0, 6'd0, 4'h0, 0);
    do_req(0, 1'b0, 6'd9,  4'h0, "rd9",  0, 6'd0, 4'h0, 0);

    // Inputs changed during WAIT are ignored
    do_req(0, 1'b1, 6'd10, 4'h6, "wr10_chg", 1, 6'd11, 4'h9, 0);
    do_req(0, 1'b0, 6'd10, 4'h0, "rd10", 0, 6'd0, 4'h0, 0);
    do_req(0, 1'b0, 6'd11, 4'h0, "rd11", 0, 6'd0, 4'h0, 0);

    // Held valid: back-to-back reads, pulse period WAIT_STATES+2
    do_req(0, 1'b0, 6'd3,  4'h0, "b2b_1", 0, 6'd0, 4'h0, 1);
    do_req(0, 1'b0, 6'd63, 4'h0, "b2b_2", 0, 6'd0, 4'h0, 0);

    // Zero wait states, non-power-of-two depth, out-of-range accesses
    do_req(1, 1'b1, 6'd5,  4'h3, "b_wr5",  0, 6'd0, 4'h0, 0);
    do_req(1, 1'b0, 6'd5,  4'h0, "b_rd5",  0, 6'd0, 4'h0, 0);
    do_req(1, 1'b1, 6'd50, 4'h7, "b_wr50", 0, 6'd0, 4'h0, 0);
    do_req(1, 1'b0, 6'd50, 4'h0, "b_rd50", 0, 6'd0, 4'h0, 0);
    do_req(1, 1'b1, 6'd47, 4'hC, "b_wr47", 0, 6'd0, 4'h0, 0);
    do_req(1, 1'b0, 6'd47, 4'h0, "b_rd47", 0, 6'd0, 4'h0, 0);
    do_req(1, 1'b0, 6'd2,  4'h0, "b_rd2",  0, 6'd0, 4'h0, 0);

    // Reset while a write sits in WAIT: no pulse, no commit
    drive(0, 1'b1, 1'b1, 6'd7, 4'h5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 6'd0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("midrst_rdy", 32'(bus_a.ready_o), 32'(0));
    end
    rst = 1'b0;
    reset_model();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("postrst_rdy", 32'(bus_a.ready_o), 32'(0));
    end
    check("postrst_rdata", 32'(bus_a.rdata_o), 32'(0));
    do_req(0, 1'b0, 6'd7, 4'h0, "rd7_after_rst", 0, 6'd0, 4'h0, 0);
    do_req(0, 1'b0, 6'd3, 4'h0, "rd3_after_rst", 0, 6'd0, 4'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
